// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory bus: read-owner tags,
// byte-enable patterns and the alignment rule used by the misalignment check.
package riscv_mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } rd_owner_t;

  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_B0      = 4'b0001;
  localparam logic [BE_W-1:0] BE_B1      = 4'b0010;
  localparam logic [BE_W-1:0] BE_B2      = 4'b0100;
  localparam logic [BE_W-1:0] BE_B3      = 4'b1000;

  // Payload of the request that won arbitration (address kept separate, it is parameterised).
  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  // Illegal enable pattern, or enables that do not fit the low address bits.
  function automatic logic is_misaligned(input logic [BE_W-1:0] be, input logic [1:0] lo);
    logic bad;
    case (be)
      BE_WORD:                       bad = (lo != 2'b00);
      BE_HALF_LO, BE_HALF_HI:        bad = lo[0];
      BE_B0, BE_B1, BE_B2, BE_B3:    bad = 1'b0;
      default:                       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles a pending dbg request has lost;
// force_o tells the arbiter to hand the next cycle to dbg.
module dmem_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_o
);

  localparam int unsigned CNT_W = 4;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dmem_starve_ctr: MAX_WAIT must be in 1..15");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_W'(MAX_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter in front of the single-port data RAM. Core has priority,
// dbg is forced through after MAX_WAIT lost cycles. Optional MISALIGN_CHECK_EN.
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [XLEN-1:0]     core_wdata,
  input  logic [BE_W-1:0]     core_be,
  output logic                core_stall,
  output logic [XLEN-1:0]     core_rdata,
  output logic                core_rvalid,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [XLEN-1:0]     dbg_wdata,
  input  logic [BE_W-1:0]     dbg_be,
  output logic                dbg_gnt,
  output logic [XLEN-1:0]     dbg_rdata,
  output logic                dbg_rvalid,
  output logic                mem_en,
  output logic [BE_W-1:0]     mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata
`ifdef MISALIGN_CHECK_EN
  ,
  output logic                misalign_err,
  output logic [ADDR_W-1:0]   misalign_addr
`endif
);

  logic            force_win;
  logic            dbg_win;
  logic            core_win;
  logic            any_win;
  logic            bad;
  mem_req_t        sel;
  logic [ADDR_W-1:0] sel_addr;

  rd_owner_t       own_q, own_d;
  logic [XLEN-1:0] core_hold_q, core_hold_d;
  logic [XLEN-1:0] dbg_hold_q, dbg_hold_d;
  logic [XLEN-1:0] ret_data;

  dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (dbg_req),
    .gnt_i   (dbg_win),
    .force_o (force_win)
  );

  assign dbg_win    = dbg_req & (~core_req | force_win);
  assign core_win   = core_req & ~dbg_win;
  assign any_win    = core_win | dbg_win;
  assign core_stall = core_req & ~core_win;
  assign dbg_gnt    = dbg_win;

  // Winner mux; everything is zero when nobody is granted.
  always_comb begin
    sel      = '0;
    sel_addr = '0;
    if (core_win) begin
      sel.we    = core_we;
      sel.be    = core_be;
      sel.wdata = core_wdata;
      sel_addr  = core_addr;
    end else if (dbg_win) begin
      sel.we    = dbg_we;
      sel.be    = dbg_be;
      sel.wdata = dbg_wdata;
      sel_addr  = dbg_addr;
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic              rd_bad_q;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  assign bad      = any_win & is_misaligned(sel.be, sel_addr[1:0]);
  assign ret_data = rd_bad_q ? '0 : mem_rdata;

  // Sticky error; the address of the first offender is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bad_q   <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      rd_bad_q <= bad;
      if (bad && !err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= sel_addr;
      end
    end
  end

  assign misalign_err  = err_q;
  assign misalign_addr = err_addr_q;
`else
  logic unused_addr_lo;

  assign bad            = 1'b0;
  assign ret_data       = mem_rdata;
  assign unused_addr_lo = ^sel_addr[1:0];
`endif

  assign mem_en    = any_win & ~bad;
  assign mem_we    = sel.be & {BE_W{sel.we & ~bad}};
  assign mem_addr  = sel_addr[ADDR_W-1:2];
  assign mem_wdata = sel.wdata;

  // Tag the owner of a granted read; data returns to it on the following cycle.
  always_comb begin
    own_d       = OWN_NONE;
    core_hold_d = core_hold_q;
    dbg_hold_d  = dbg_hold_q;
    if (core_win && !core_we) begin
      own_d = OWN_CORE;
    end else if (dbg_win && !dbg_we) begin
      own_d = OWN_DBG;
    end
    if (own_q == OWN_CORE) begin
      core_hold_d = ret_data;
    end
    if (own_q == OWN_DBG) begin
      dbg_hold_d = ret_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q       <= OWN_NONE;
      core_hold_q <= '0;
      dbg_hold_q  <= '0;
    end else begin
      own_q       <= own_d;
      core_hold_q <= core_hold_d;
      dbg_hold_q  <= dbg_hold_d;
    end
  end

  assign core_rvalid = (own_q == OWN_CORE);
  assign dbg_rvalid  = (own_q == OWN_DBG);
  assign core_rdata  = core_rvalid ? ret_data : core_hold_q;
  assign dbg_rdata   = dbg_rvalid ? ret_data : dbg_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM, reference model of arbitration and
// memory contents, directed scenarios followed by randomized traffic.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned WORDS    = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              core_req, core_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] core_addr, dbg_addr;
  logic [31:0]       core_wdata, dbg_wdata;
  logic [3:0]        core_be, dbg_be;
  logic              core_stall, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0]       core_rdata, dbg_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
`ifdef MISALIGN_CHECK_EN
  logic              misalign_err;
  logic [ADDR_W-1:0] misalign_addr;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_stall(core_stall),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_be(dbg_be), .dbg_gnt(dbg_gnt),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MISALIGN_CHECK_EN
    , .misalign_err(misalign_err), .misalign_addr(misalign_addr)
`endif
  );

  // Single-port synchronous RAM with byte strobes.
  logic [31:0] ram [WORDS] = '{default: 32'h0};
  logic [31:0] ram_rd_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) ram_rd_q <= ram[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = ram_rd_q;

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  int          losses;          // consecutive cycles a pending dbg request was refused
  int          pend;            // 0 none, 1 core, 2 dbg: read returning next cycle
  logic [31:0] pend_data, core_last, dbg_last;
  // Expected winner and its access for the current cycle
  logic              e_core_win, e_dbg_win, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [3:0]        e_be;
  logic [31:0]       e_wdata;
  // DUT outputs sampled in the current cycle
  logic        s_stall, s_gnt, s_crv, s_drv;
  logic [3:0]  s_we;
  logic [31:0] s_crd, s_drd;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    losses    = 0;
    pend      = 0;
    pend_data = '0;
    core_last = '0;
    dbg_last  = '0;
  endtask

  // Check all outputs against the model for the current input set.
  task automatic compare_cycle();
    e_dbg_win  = dbg_req && (!core_req || losses >= int'(MAX_WAIT));
    e_core_win = core_req && !e_dbg_win;
    e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
    if (e_core_win) begin
      e_we = core_we; e_addr = core_addr; e_be = core_be; e_wdata = core_wdata;
    end else if (e_dbg_win) begin
      e_we = dbg_we; e_addr = dbg_addr; e_be = dbg_be; e_wdata = dbg_wdata;
    end
    s_stall = core_stall; s_gnt = dbg_gnt; s_we = mem_we;
    s_crv = core_rvalid; s_drv = dbg_rvalid; s_crd = core_rdata; s_drd = dbg_rdata;
    chk("core_stall", 32'(core_stall), 32'(core_req && !e_core_win));
    chk("dbg_gnt",    32'(dbg_gnt),    32'(e_dbg_win));
    chk("mem_en",     32'(mem_en),     32'(e_core_win || e_dbg_win));
    chk("mem_we",     32'(mem_we),     32'(e_we ? e_be : 4'b0000));
    chk("mem_addr",   32'(mem_addr),   32'(e_addr >> 2));
    chk("mem_wdata",  mem_wdata,       e_wdata);
    chk("core_rvalid", 32'(core_rvalid), 32'(pend == 1));
    chk("dbg_rvalid",  32'(dbg_rvalid),  32'(pend == 2));
    chk("core_rdata",  core_rdata, (pend == 1) ? pend_data : core_last);
    chk("dbg_rdata",   dbg_rdata,  (pend == 2) ? pend_data : dbg_last);
  endtask

  task automatic update_model();
    int w;
    if (pend == 1) core_last = pend_data;
    else if (pend == 2) dbg_last = pend_data;
    pend = 0;
    w = int'(e_addr >> 2);
    if (e_core_win || e_dbg_win) begin
      if (e_we) begin
        for (int b = 0; b < 4; b++)
          if (e_be[b]) ref_mem[w][8*b +: 8] = e_wdata[8*b +: 8];
      end else begin
        pend      = e_core_win ? 1 : 2;
        pend_data = ref_mem[w];
      end
    end
    if (dbg_req && !e_dbg_win) losses = (losses < int'(MAX_WAIT)) ? losses + 1 : losses;
    else losses = 0;
    if (!rst_n) model_reset();
  endtask

  // One clock: check mid-cycle, advance model at the edge, return just after it.
  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    core_req = req; core_we = we; core_addr = a; core_wdata = wd; core_be = be;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_be = be;
  endtask

  // Random legal access over a 16-word window to provoke same-address traffic.
  task automatic rand_access(output logic we, output logic [ADDR_W-1:0] a,
                             output logic [31:0] wd, output logic [3:0] be);
    logic [7:0] w;
    logic [1:0] lo;
    int         b;
    w  = 8'($urandom_range(0, 15));
    we = 1'($urandom_range(0, 1));
    wd = $urandom();
    case ($urandom_range(0, 2))
      0: begin be = 4'b1111; lo = 2'b00; end
      1: begin b = 2 * int'($urandom_range(0, 1)); be = 4'b0011 << b; lo = 2'(b); end
      default: begin b = int'($urandom_range(0, 3)); be = 4'b0001 << b; lo = 2'(b); end
    endcase
    a = {w, lo};
  endtask

  initial begin
    int          first_gnt, n_gnt;
    logic [31:0] gnt_mask, stall_mask;
    logic        r_we;
    logic [ADDR_W-1:0] r_a;
    logic [31:0] r_wd;
    logic [3:0]  r_be;

    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = '0;
    model_reset();
    set_core(0, 0, '0, '0, '0);
    set_dbg(0, 0, '0, '0, '0);
    #1 rst_n = 1'b0;
    step();
    step();
    chk("reset_core_rvalid", 32'(s_crv), 32'h0);
    chk("reset_core_rdata", s_crd, 32'h0);
    rst_n = 1'b1;
    step();

    // Core store then load of the same word.
    set_core(1, 1, 10'h008, 32'hDEADBEEF, 4'b1111);
    step();
    chk("sw_mem_we", 32'(s_we), 32'hF);
    chk("sw_stall", 32'(s_stall), 32'h0);
    set_core(1, 0, 10'h008, '0, 4'b1111);
    step();
    chk("lw_stall", 32'(s_stall), 32'h0);
    set_core(0, 0, '0, '0, '0);
    step();
    chk("lw_rvalid", 32'(s_crv), 32'h1);
    chk("lw_rdata", s_crd, 32'hDEADBEEF);

    // Debug-only writes, then a core load from the middle.
    for (int i = 0; i < 5; i++) begin
      int vals[5] = '{5, 1, 4, 2, 8};
      set_dbg(1, 1, 10'(8 + 4 * i), 32'(vals[i]), 4'b1111);
      step();
      chk("dbg_wr_gnt", 32'(s_gnt), 32'h1);
    end
    set_dbg(0, 0, '0, '0, '0);
    set_core(1, 0, 10'h010, '0, 4'b1111);
    step();
    set_core(0, 0, '0, '0, '0);
    step();
    chk("dbg_fill_lw", s_crd, 32'h00000004);

    // Core byte store merged into a word written by dbg.
    set_dbg(1, 1, 10'h00C, 32'h11223344, 4'b1111);
    step();
    set_dbg(0, 0, '0, '0, '0);
    set_core(1, 1, 10'h00D, 32'h0000AA00, 4'b0010);
    step();
    set_core(0, 0, '0, '0, '0);
    set_dbg(1, 0, 10'h00C, '0, 4'b1111);
    step();
    set_dbg(0, 0, '0, '0, '0);
    step();
    chk("sb_merge_rvalid", 32'(s_drv), 32'h1);
    chk("sb_merge_rdata", s_drd, 32'h1122AA44);

    // Reset lands while a dbg read is in flight.
    set_dbg(1, 0, 10'h00C, '0, 4'b1111);
    step();
    rst_n = 1'b0;
    set_dbg(0, 0, '0, '0, '0);
    model_reset();
    step();
    chk("rst_mid_rvalid", 32'(s_drv), 32'h0);
    chk("rst_mid_rdata", s_drd, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rst_after_rvalid", 32'(s_drv), 32'h0);

    // Continuous contention: dbg forced through every MAX_WAIT+1 cycles.
    first_gnt = 0; n_gnt = 0; gnt_mask = '0; stall_mask = '0;
    set_core(1, 0, 10'h020, '0, 4'b1111);
    set_dbg(1, 0, 10'h024, '0, 4'b1111);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (s_gnt) begin
        n_gnt++;
        if (first_gnt == 0) first_gnt = k;
        gnt_mask[k-1] = 1'b1;
      end
      if (s_stall) stall_mask[k-1] = 1'b1;
    end
    chk("force_first_gnt", 32'(first_gnt), 32'd5);
    chk("force_n_gnt", 32'(n_gnt), 32'd4);
    chk("force_gnt_mask", gnt_mask, 32'h00084210);
    chk("force_stall_mask", stall_mask, 32'h00084210);
    set_core(0, 0, '0, '0, '0);
    set_dbg(0, 0, '0, '0, '0);
    step();

    // Randomized traffic obeying the hold-while-stalled / hold-until-grant rules.
    for (int n = 0; n < 3000; n++) begin
      if (!(core_req && !e_core_win)) begin
        rand_access(r_we, r_a, r_wd, r_be);
        set_core(($urandom_range(0, 3) != 0), r_we, r_a, r_wd, r_be);
      end
      if (!(dbg_req && !e_dbg_win)) begin
        rand_access(r_we, r_a, r_wd, r_be);
        set_dbg(($urandom_range(0, 2) == 0), r_we, r_a, r_wd, r_be);
      end
      step();
    end
    set_core(0, 0, '0, '0, '0);
    set_dbg(0, 0, '0, '0, '0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
